// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared store/load encodings, FSM states and alignment helper
package mem_access_unit_pkg;

    localparam int unsigned WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_type_e;

    typedef enum logic [2:0] {
        LT_NOREGWRITE = 3'd0,
        LT_LB         = 3'd1,
        LT_LH         = 3'd2,
        LT_LW         = 3'd3,
        LT_LBU        = 3'd4,
        LT_LHU        = 3'd5
    } load_type_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [1:0] st,
                                           input logic [2:0] lt,
                                           input logic [1:0] byte_off);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            if (st == ST_SH) mis = byte_off[0];
            else if (st == ST_SW) mis = (byte_off != 2'b00);
        end else begin
            if (lt == LT_LH || lt == LT_LHU) mis = byte_off[0];
            else if (lt == LT_LW) mis = (byte_off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// rtl/mem_access_unit_store_align.sv - store byte enables and lane replication
module store_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] store_data
);

    // Replicate the store operand across all lanes so the enabled lane always carries it.
    always_comb begin
        we         = 4'b0000;
        store_data = 32'd0;
        case (store_type)
            ST_SB: begin
                we         = 4'b0001 << byte_off;
                store_data = {4{wdata[7:0]}};
            end
            ST_SH: begin
                we         = 4'b0011 << {byte_off[1], 1'b0};
                store_data = {2{wdata[15:0]}};
            end
            ST_SW: begin
                we         = 4'b1111;
                store_data = wdata;
            end
            ST_NONE: begin
                we         = 4'b0000;
                store_data = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with timeout and WB payload
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic        mem_rd,
    output logic        stall,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wb_word,
    output logic [1:0]  wb_byte_sel,
    output logic [2:0]  wb_reg_write,
    output logic        wb_valid,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_e                  state;
    state_e                  state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    logic                    is_store;
    logic                    is_load;
    logic                    mis;
    logic                    access_go;
    logic                    ack_ok;
    logic                    timeout;
    logic [3:0]              sa_we;
    logic [31:0]             sa_data;

    // A store takes precedence when both the load flag and a store type are present.
    assign is_store  = valid && (store_type != ST_NONE);
    assign is_load   = valid && mem_rd && (store_type == ST_NONE);
    assign mis       = (is_store || is_load) && is_misaligned(is_store, store_type, load_type, addr[1:0]);
    assign access_go = (is_store || is_load) && !mis;
    assign ack_ok    = (state == S_BUSY) && mem_req && mem_ack;
    assign timeout   = (state == S_BUSY) && !mem_ack && (wait_cnt == TIMEOUT_LAST);

    store_align u_store_align (
        .store_type (store_type),
        .byte_off   (addr[1:0]),
        .wdata      (wdata),
        .we         (sa_we),
        .store_data (sa_data)
    );

    // Next state and the combinational pipeline freeze.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            S_IDLE: if (access_go) state_next = S_BUSY;
            S_BUSY: if (ack_ok || timeout) state_next = S_IDLE;
        endcase
        if (!rst && access_go && !(ack_ok || timeout)) stall = 1'b1;
    end

    // State register and wait counter; the counter restarts whenever the FSM is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) wait_cnt <= '0;
            else if (!mem_ack) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Memory request: launched from idle, held until ack or abandon.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= '0;
            mem_wdata <= '0;
        end else if (state == S_IDLE && access_go) begin
            mem_req   <= 1'b1;
            mem_addr  <= addr[31:2];
            mem_we    <= sa_we;
            mem_wdata <= sa_data;
        end else if (ack_ok || timeout) begin
            mem_req   <= 1'b0;
        end
    end

    // WB payload advances only on unstalled edges so each instruction appears once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_word      <= '0;
            wb_byte_sel  <= '0;
            wb_reg_write <= '0;
            wb_valid     <= 1'b0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else if (!stall) begin
            wb_word      <= (ack_ok && is_load) ? mem_rdata : 32'd0;
            wb_byte_sel  <= addr[1:0];
            wb_reg_write <= ((store_type != ST_NONE) || mis || timeout) ? 3'd0 : load_type;
            wb_valid     <= valid;
            misalign     <= mis;
            bus_err      <= timeout;
        end else begin
            wb_reg_write <= '0;
            wb_valid     <= 1'b0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  store_type = '0;
    logic [2:0]  load_type = '0;
    logic        mem_rd = 1'b0;
    logic        stall;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] wb_word;
    logic [1:0]  wb_byte_sel;
    logic [2:0]  wb_reg_write;
    logic        wb_valid;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic        rd;
        int          delay;
        logic [31:0] rdata;
        logic [29:0] e_maddr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        int          e_stall;
        int          e_nreq;
        logic [31:0] e_word;
        logic [1:0]  e_sel;
        logic [2:0]  e_rw;
        logic        e_mis;
        logic        e_berr;
    } vec_t;

    vec_t vecs[14];

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .addr         (addr),
        .wdata        (wdata),
        .store_type   (store_type),
        .load_type    (load_type),
        .mem_rd       (mem_rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_word      (wb_word),
        .wb_byte_sel  (wb_byte_sel),
        .wb_reg_write (wb_reg_write),
        .wb_valid     (wb_valid),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid = 1'b0; addr = '0; wdata = '0; store_type = '0; load_type = '0; mem_rd = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int nstall;
        int nreq;
        bit done;
        nstall = 0; nreq = 0; done = 0;
        valid = t.v; addr = t.a; wdata = t.wd; store_type = t.st; load_type = t.lt; mem_rd = t.rd;
        mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (c > 0) chk($sformatf("v%0d wb_valid_in_stall", idx), 32'(wb_valid), 32'd0);
            if (mem_req) begin
                nreq++;
                chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(t.e_maddr));
                chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(t.e_we));
                if (t.st != 2'd0) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, t.e_wdata);
                if (nreq > t.delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = t.rdata;
                end
                #1;
            end
            if (stall) nstall++;
            else done = 1;
            tick();
            mem_ack = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL v%0d stall_release: stall never released within bound", idx);
        end
        #1;
        chk($sformatf("v%0d stall_cycles", idx), 32'(nstall), 32'(t.e_stall));
        chk($sformatf("v%0d req_cycles", idx), 32'(nreq), 32'(t.e_nreq));
        chk($sformatf("v%0d mem_req_after", idx), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d wb_word", idx), wb_word, t.e_word);
        chk($sformatf("v%0d wb_byte_sel", idx), 32'(wb_byte_sel), 32'(t.e_sel));
        chk($sformatf("v%0d wb_reg_write", idx), 32'(wb_reg_write), 32'(t.e_rw));
        chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(t.e_mis));
        chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(t.e_berr));
        clear_inputs();
        tick();
        chk($sformatf("v%0d wb_valid_single", idx), 32'(wb_valid), 32'd0);
    endtask

    initial begin
        //           v     addr        wdata         st    lt    rd    dly  rdata         maddr     we       wdata_e       stl nrq word          sel   rw    mis   berr
        vecs[0]  = '{1'b1, 32'h104, 32'h0,        2'd0, 3'd3, 1'b1, 0,   32'hDEADBEEF, 30'h41,  4'b0000, 32'h0,        1,  1,  32'hDEADBEEF, 2'd0, 3'd3, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h203, 32'hA5,       2'd1, 3'd0, 1'b0, 3,   32'h0,        30'h80,  4'b1000, 32'hA5A5A5A5, 4,  4,  32'h0,        2'd3, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h101, 32'h0,        2'd0, 3'd2, 1'b1, 0,   32'h0,        30'h0,   4'b0000, 32'h0,        0,  0,  32'h0,        2'd1, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h40,  32'h0,        2'd0, 3'd4, 1'b1, 100, 32'h0,        30'h10,  4'b0000, 32'h0,        4,  4,  32'h0,        2'd0, 3'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 32'h2,   32'h1234ABCD, 2'd2, 3'd0, 1'b0, 0,   32'h0,        30'h0,   4'b1100, 32'hABCDABCD, 1,  1,  32'h0,        2'd2, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h3,   32'h0,        2'd0, 3'd4, 1'b1, 1,   32'h11223344, 30'h0,   4'b0000, 32'h0,        2,  2,  32'h11223344, 2'd3, 3'd4, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h102, 32'h5555,     2'd3, 3'd0, 1'b0, 0,   32'h0,        30'h0,   4'b0000, 32'h0,        0,  0,  32'h0,        2'd2, 3'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h106, 32'h0,        2'd0, 3'd5, 1'b1, 2,   32'hCAFEF00D, 30'h41,  4'b0000, 32'h0,        3,  3,  32'hCAFEF00D, 2'd2, 3'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h10,  32'h123456FF, 2'd1, 3'd1, 1'b1, 0,   32'h55555555, 30'h4,   4'b0001, 32'hFFFFFFFF, 1,  1,  32'h0,        2'd0, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h7,   32'h0,        2'd0, 3'd0, 1'b0, 0,   32'h0,        30'h0,   4'b0000, 32'h0,        0,  0,  32'h0,        2'd3, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h101, 32'h0,        2'd0, 3'd3, 1'b1, 0,   32'h0,        30'h0,   4'b0000, 32'h0,        0,  0,  32'h0,        2'd1, 3'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h205, 32'h0,        2'd2, 3'd0, 1'b0, 0,   32'h0,        30'h0,   4'b0000, 32'h0,        0,  0,  32'h0,        2'd1, 3'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h7,   32'h0,        2'd0, 3'd1, 1'b1, 0,   32'h000000F0, 30'h1,   4'b0000, 32'h0,        1,  1,  32'h000000F0, 2'd3, 3'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h1FC, 32'h89ABCDEF, 2'd3, 3'd0, 1'b0, 0,   32'h0,        30'h7F,  4'b1111, 32'h89ABCDEF, 1,  1,  32'h0,        2'd0, 3'd0, 1'b0, 1'b0};

        // reset with a needed access presented
        rst = 1'b1;
        valid = 1'b1; addr = 32'h104; load_type = 3'd3; mem_rd = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        tick();
        chk("rst_stall_held", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_word", wb_word, 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        clear_inputs();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // reset in the second BUSY cycle of a SW abandons it
        valid = 1'b1; addr = 32'h300; wdata = 32'h01020304; store_type = 2'd3;
        #1;
        chk("rb_stall0", 32'(stall), 32'd1);
        tick();
        chk("rb_req_busy1", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rb_stall_in_rst", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("rb_req_after_rst", 32'(mem_req), 32'd0);
        chk("rb_wb_valid_after_rst", 32'(wb_valid), 32'd0);
        tick();
        chk("rb_req_later", 32'(mem_req), 32'd0);
        chk("rb_wb_valid_later", 32'(wb_valid), 32'd0);
        run_vec(vecs[0], 100);

        // back-to-back SH then LBU
        valid = 1'b1; addr = 32'h2; wdata = 32'h0000BEEF; store_type = 2'd2;
        #1;
        chk("bb_sh_stall", 32'(stall), 32'd1);
        tick();
        chk("bb_sh_req", 32'(mem_req), 32'd1);
        chk("bb_sh_we", 32'(mem_we), 32'hC);
        chk("bb_sh_wdata", mem_wdata, 32'hBEEFBEEF);
        mem_ack = 1'b1;
        #1;
        chk("bb_sh_stall_ack", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        clear_inputs();
        valid = 1'b1; addr = 32'h3; load_type = 3'd4; mem_rd = 1'b1;
        #1;
        chk("bb_sh_wb_valid", 32'(wb_valid), 32'd1);
        chk("bb_sh_sel", 32'(wb_byte_sel), 32'd2);
        chk("bb_sh_rw", 32'(wb_reg_write), 32'd0);
        chk("bb_lbu_stall", 32'(stall), 32'd1);
        tick();
        chk("bb_gap_wb_valid", 32'(wb_valid), 32'd0);
        chk("bb_lbu_req", 32'(mem_req), 32'd1);
        chk("bb_lbu_we", 32'(mem_we), 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hA1B2C3D4;
        #1;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        clear_inputs();
        #1;
        chk("bb_lbu_wb_valid", 32'(wb_valid), 32'd1);
        chk("bb_lbu_sel", 32'(wb_byte_sel), 32'd3);
        chk("bb_lbu_rw", 32'(wb_reg_write), 32'd4);
        chk("bb_lbu_word", wb_word, 32'hA1B2C3D4);
        tick();
        chk("bb_end_wb_valid", 32'(wb_valid), 32'd0);

        // stray ack with no request outstanding
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("stray_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_wb_valid", 32'(wb_valid), 32'd0);
        chk("stray_wb_word", wb_word, 32'd0);
        run_vec(vecs[12], 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of BUSY cycles without mem_ack before the access is abandoned.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port valid  in  1  MEM-stage instruction present.
REQ-005 SHALL have port addr  in  32  byte address (ALU result).
REQ-006 SHALL have port wdata  in  32  store source register value.
REQ-007 SHALL have port store_type  in  2  0 none, 1 SB, 2 SH, 3 SW.
REQ-008 SHALL have port load_type  in  3  register-write mode: 0 NOREGWRITE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
REQ-009 SHALL have port mem_rd  in  1  instruction is a load.
REQ-010 SHALL have port stall  out  1  freeze upstream stages this cycle.
REQ-011 SHALL have ports mem_req out 1, mem_addr out 30 (word address), mem_we out 4 (byte enables), mem_wdata out 32: memory request.
REQ-012 SHALL have ports mem_ack in 1 and mem_rdata in 32: memory response, rdata valid when ack high.
REQ-013 SHALL have ports wb_word out 32, wb_byte_sel out 2, wb_reg_write out 3, wb_valid out 1: registered WB-stage payload for the downstream load extender.
REQ-014 SHALL have ports misalign out 1 and bus_err out 1: registered one-cycle exception flags aligned with wb_valid.

Function
REQ-015 Access SHALL be needed when valid and (mem_rd or store_type!=0); if both are set, the instruction is a store and wb_reg_write is 0.
REQ-016 Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; no memory request, no stall, wb_valid=1, misalign=1, wb_reg_write=0.
REQ-017 FSM states SHALL be IDLE and BUSY: IDLE->BUSY on an aligned needed access; BUSY->IDLE on mem_ack or timeout.
REQ-018 In BUSY, mem_req=1 with mem_addr=addr[31:2], mem_we and mem_wdata held stable until the edge at which mem_ack is sampled high.
REQ-019 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-020 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-021 stall SHALL be combinational: 1 when an aligned access is needed and not (state==BUSY and mem_ack); stall=0 otherwise.
REQ-022 Minimum latency: valid at cycle 0 -> mem_req cycle 1 -> ack cycle 1 -> wb_valid and data at cycle 2; each extra wait cycle adds one.
REQ-023 WB registers SHALL update on every edge where stall=0: wb_word=mem_rdata for completed loads, else 0; wb_byte_sel=addr[1:0]; wb_reg_write=load_type, or 0 on store, misalign or bus_err; wb_valid=valid.
REQ-024 wb_valid SHALL be 0 after an edge where stall=1; WB outputs are never duplicated.
REQ-025 A 16-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without ack.
REQ-026 When the counter reaches TIMEOUT-1 without ack: drop mem_req, return to IDLE, release stall that cycle, wb_valid=1, bus_err=1, wb_reg_write=0.
REQ-027 If mem_ack and timeout occur in the same cycle, mem_ack SHALL win.
REQ-028 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-029 On a rising edge with rst=1: state IDLE, counter 0, mem_req, mem_we, mem_wdata, mem_addr, wb_* , misalign and bus_err all 0.
REQ-030 Reset during BUSY SHALL abandon the access: mem_req=0 from the following cycle, no wb_valid for the abandoned access.
REQ-031 While rst=1, stall SHALL be 0.

Structure
REQ-032 Store-type and register-write-mode encodings SHALL live in the shared parameters package, the same encodings consumed by the load extender.
REQ-033 Byte-enable and store-data replication SHALL be one combinational sub-module, store_align.
REQ-034 The FSM, counter and WB registers SHALL stay in mem_access_unit.

Verification
REQ-035 LW addr=0x104, ack same cycle as req, rdata=0xDEADBEEF: stall 1 for 1 cycle; wb_word=0xDEADBEEF, wb_reg_write=3, wb_byte_sel=0.
REQ-036 SB addr=0x203, wdata=0x000000A5, ack after 3 wait cycles: mem_we=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80, stall for 4 cycles, wb_reg_write=0.
REQ-037 LH addr=0x101: no mem_req, stall 0, misalign=1, wb_reg_write=0.
REQ-038 LBU addr=0x40, TIMEOUT=4, no ack: mem_req high 4 cycles then low, bus_err=1, stall released.
REQ-039 rst=1 in the 2nd BUSY cycle of an SW: mem_req=0 next cycle, no wb_valid; the next LW completes normally.
REQ-040 Back-to-back SH addr=0x2 then LBU addr=0x3: mem_we=4'b1100, then wb_byte_sel=3, one wb_valid per instruction.
